// File: rtl/signext_pkg.sv
`default_nettype none
// ==========================================================================
// signext_pkg: formats, opcodes and result record for the LEGv8 extender.
// Rev 1.0
// ==========================================================================
package signext_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_CB   = 3'd1,
    FMT_B    = 3'd2,
    FMT_D    = 3'd3,
    FMT_I    = 3'd4,
    FMT_IW   = 3'd5
  } fmt_t;

  localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;
  localparam logic [7:0]  OP_CBNZ = 8'b1011_0101;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;
  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [9:0]  OP_ADDI = 10'b10_0100_0100;
  localparam logic [9:0]  OP_SUBI = 10'b11_0100_0100;
  localparam logic [8:0]  OP_MOVZ = 9'b1_1010_0101;

  // Immediate is carried at the widest legal N; narrower builds zero the top.
  localparam int IMM_W = 64;

  typedef struct packed {
    logic [IMM_W-1:0] imm;
    fmt_t             fmt;
    logic             illegal;
  } signext_res_t;

endpackage
`default_nettype wire

// File: rtl/signext_decode.sv
`default_nettype none
// ==========================================================================
// signext_decode: combinational instr -> {imm, fmt, illegal} classifier.
// Rev 1.0 | option SIGNEXT_SHL2_EN: CB/B immediates become byte offsets.
// ==========================================================================
module signext_decode
  import signext_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [31:0]  instr,
  output signext_res_t res
);

`ifdef SIGNEXT_SHL2_EN
  localparam int BR_SHL = 2;
`else
  localparam int BR_SHL = 0;
`endif

  logic [63:0] w_ext;

  always_comb begin
    res   = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};
    w_ext = '0;
    if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
      w_ext   = {{45{instr[23]}}, instr[23:5]} << BR_SHL;
      res.fmt = FMT_CB;
    end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
      w_ext   = {{38{instr[25]}}, instr[25:0]} << BR_SHL;
      res.fmt = FMT_B;
    end else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      w_ext   = {{55{instr[20]}}, instr[20:12]};
      res.fmt = FMT_D;
    end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
      w_ext   = {52'd0, instr[21:10]};
      res.fmt = FMT_I;
    end else if (instr[31:23] == OP_MOVZ) begin
      w_ext   = {48'd0, instr[20:5]} << {instr[22:21], 4'b0000};
      res.fmt = FMT_IW;
    end else begin
      res.illegal = 1'b1;
    end
    // Truncation to N drops MOVZ hw>=2 to zero on 32-bit builds.
    res.imm = IMM_W'(w_ext[N-1:0]);
  end

endmodule
`default_nettype wire

// File: rtl/signext_pipe.sv
`default_nettype none
// ==========================================================================
// signext_pipe: registered LEGv8 immediate extender with 2-entry skid buffer.
// Rev 1.0 | option SIGNEXT_SHL2_EN: CB/B immediates become byte offsets.
// ==========================================================================
module signext_pipe
  import signext_pkg::*;
#(
  parameter int N     = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_imm,
  output fmt_t             out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  if (N != 32 && N != 64) begin : g_bad_n
    $error("signext_pipe: N must be 32 or 64");
  end

  signext_res_t     w_dec;
  signext_res_t     r_out;
  signext_res_t     r_skid;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_out_fire;

  signext_decode #(.N(N)) u_decode (
    .instr (instr),
    .res   (w_dec)
  );

  assign w_accept   = in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // The skid entry is full exactly when in_ready is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out       <= '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};
      r_skid      <= '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_cnt       <= '0;
    end else begin
      if (w_out_fire && !r_in_ready) begin
        r_out      <= r_skid;
        r_in_ready <= 1'b1;
      end else if (w_accept) begin
        if (!r_out_valid || w_out_fire) begin
          r_out       <= w_dec;
          r_out_valid <= 1'b1;
        end else begin
          r_skid     <= w_dec;
          r_in_ready <= 1'b0;
        end
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end

      if (w_out_fire && r_out.illegal && r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_out.imm[N-1:0];
  assign out_fmt     = r_out.fmt;
  assign out_illegal = r_out.illegal;
  assign illegal_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/signext_pipe.md
Name: signext_pipe

Overview:
- Pipelined, parametrised successor to the decode-stage sign extender.
- Classifies a 32-bit LEGv8 instruction, extracts its immediate and extends it to N bits.
- Supports CB, B, D, I and IW (MOVZ) formats, with a valid/ready handshake on both sides and a 2-entry skid buffer.
- Flags unsupported encodings and counts them; sits between fetch/decode and the ID/EX register.

Parameters:
- N, 64, output immediate width; legal values are 32 and 64, anything else fails elaboration.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept an instruction this cycle.
- instr  in  32  instruction word.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_imm  out  N  extended immediate.
- out_fmt  out  3  format code, type fmt_t.
- out_illegal  out  1  encoding not recognised.
- illegal_cnt  out  CNT_W  count of illegal results delivered.

Behaviour:
- Reset (synchronous, active-high, wins over every other event):
  - out_valid=0, out_imm=0, out_fmt=FMT_NONE, out_illegal=0, illegal_cnt=0.
  - Skid buffer emptied; in_ready=1 from the first cycle after reset.
- Decode (combinational, on instr):
  - CB, [31:24]=10110100 or 10110101: sign-extend imm19=[23:5].
  - B, [31:26]=000101 or 100101: sign-extend imm26=[25:0].
  - D, [31:21]=11111000010 (LDUR) or 11111000000 (STUR): sign-extend imm9=[20:12].
  - I, [31:22]=1001000100 (ADDI) or 1101000100 (SUBI): zero-extend imm12=[21:10].
  - IW, [31:23]=110100101 (MOVZ): zero-extend imm16=[20:5] shifted left by 16*hw, where hw=[22:21].
    - N=32 with hw>=2: result truncated to N bits, i.e. 0; out_illegal not set.
  - Anything else: imm=0, fmt=FMT_NONE, illegal=1.
- Latency:
  - Accept occurs when in_valid && in_ready.
  - The result appears on the out_* outputs on the next rising edge if the output stage is empty, or is emptying in that cycle (out_valid && out_ready).
- Backpressure:
  - If the output stage holds data and out_ready=0 on an accept, the decoded result goes to the skid entry.
  - in_ready drops to 0 the following cycle. in_ready is registered and is 0 exactly while the skid entry is full.
- Drain: when the output transfers (out_valid && out_ready) while the skid entry is full:
  - The skid contents move to the output registers.
  - in_ready returns to 1 the next cycle.
  - No accept is possible in that cycle, because in_ready=0.
- Ordering: strictly in order. No result is dropped or duplicated.
- Output hold: while out_valid=1 and out_ready=0, out_imm, out_fmt and out_illegal hold stable.
- Illegal counter:
  - Increments by 1 on each output transfer with out_illegal=1.
  - Saturates at 2^CNT_W-1; no wrap.
- in_valid=0: no state change apart from draining the output.

Optional Feature:
- Macro: SIGNEXT_SHL2_EN.
- Defined: CB and B immediates are shifted left by 2 after sign extension and before truncation to N bits, giving byte offsets. Other formats are unchanged.
- Undefined: CB and B immediates are word offsets, unshifted, and are handled by the downstream shifter.

Decomposition:
- Package signext_pkg holds:
  - typedef enum logic [2:0] fmt_t, with FMT_NONE=0, FMT_CB=1, FMT_B=2, FMT_D=3, FMT_I=4, FMT_IW=5.
  - Opcode constants OP_CBZ, OP_CBNZ, OP_B, OP_BL, OP_LDUR, OP_STUR, OP_ADDI, OP_SUBI, OP_MOVZ.
  - A packed struct signext_res_t {imm, fmt, illegal}, used for the output and skid registers.
- Sub-module signext_decode: purely combinational instr -> signext_res_t, parametrised by N.
- Top level holds the handshake, the skid buffer and the counter.

Test Plan (N=64, macro undefined unless stated):
- CB/D sign extension, in sequence with out_ready=1:
  - CBZ, imm19=23 -> out_imm=0x17, out_fmt=FMT_CB, one cycle after accept.
  - CBZ, imm19=-23 -> out_imm=0xFFFF_FFFF_FFFF_FFE9.
  - LDUR, imm9=-23 -> 0xFFFF_FFFF_FFFF_FFE9, fmt FMT_D.
  - STUR, imm9=23 -> 0x17.
- Other formats:
  - ADDI, imm12=0xFFF -> 0x0000_0000_0000_0FFF (no sign extension).
  - MOVZ, hw=2, imm16=0x1234 -> 0x0000_1234_0000_0000.
  - B, imm26=-1 -> all ones.
- Illegal encoding: instr {11'b10011000000, 9'd23, 12'b1} -> out_imm=0, FMT_NONE, out_illegal=1, illegal_cnt=1 after the transfer.
- Backpressure:
  - Hold out_ready=0 and push 3 instructions: 2 are accepted, in_ready=0 from cycle 2.
  - Release out_ready: results delivered in order, in_ready=1 one cycle after the first drain.
- Reset mid-operation: with the output and skid full, pulse reset for 1 cycle -> out_valid=0, in_ready=1, illegal_cnt=0 on the next cycle, and no stale result is emitted afterwards.
- SIGNEXT_SHL2_EN defined: CBZ imm19=23 -> 0x5C; LDUR imm9=23 -> 0x17 (unchanged); and with CNT_W=2, 4 illegal transfers -> counter stays at 3.
